// File: rtl/swap_bank.sv
// ---------------------------------------------------------------------------
// swap_bank -- DEPTH x WIDTH register bank with an in-place swap engine.
//
// A swap of entries i and j is done with three arithmetic write-backs and no
// scratch register:
//   S1: E[i] = E[i] op1 E[j]
//   S2: E[j] = E[i] op2 E[j]
//   S3: E[i] = E[i] op2 E[j]
// Default build: op1 = add, op2 = sub (all modulo 2^WIDTH).
// Define SWAP_BANK_XOR_EN to build with op1 = op2 = XOR instead; timing and
// final results are identical in both builds.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   load_en/addr/data   direct write of one entry (only honoured in IDLE)
//   cmd_valid/ready     swap request handshake, cmd_i/cmd_j are the indices
//   done                one-cycle pulse when a command finishes
//   cmd_err             one-cycle pulse with done: command had a bad index
//   load_err            one-cycle pulse: a load arrived while busy
//   busy                swap in progress (S1..S3)
//   rd_addr/rd_data     combinational read port, 0 for out-of-range index
// ---------------------------------------------------------------------------

// One storage entry: a plain WIDTH-bit register with a write enable.
module swap_bank_entry #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (we) q <= d;
endmodule

module swap_bank #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_i,
  input  logic [AW-1:0]    cmd_j,
  output logic             done,
  output logic             cmd_err,
  output logic             load_err,
  output logic             busy,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // DEPTH need not be a power of two, so every index is range-checked.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  typedef enum logic [2:0] {IDLE, S1, S2, S3, FIN} state_t;

  state_t                        state, state_nx;
  logic [AW-1:0]                 ri, rj;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic [DEPTH-1:0]              we;
  logic                          wr_any;
  logic [AW-1:0]                 wr_idx;
  logic [WIDTH-1:0]              wr_val;
  logic [WIDTH-1:0]              ei, ej, op1, op2;
  logic                          accept, cmd_bad;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign we[k] = wr_any && (wr_idx == AW'(k));
    swap_bank_entry #(.WIDTH(WIDTH)) u_ent (
      .clk (clk),
      .rst (rst),
      .we  (we[k]),
      .d   (wr_val),
      .q   (mem[k])
    );
  end

  assign rd_data = in_range(rd_addr) ? mem[rd_addr] : '0;

  // Operands always come straight from the two live entries; ri/rj are only
  // used while busy, when they are known to be in range.
  assign ei = mem[ri];
  assign ej = mem[rj];

`ifdef SWAP_BANK_XOR_EN
  assign op1 = ei ^ ej;
  assign op2 = ei ^ ej;
`else
  assign op1 = ei + ej;
  assign op2 = ei - ej;
`endif

  // Single write port: the swap step owns it while busy, a load owns it in
  // IDLE. Loads in any other state are dropped (and flagged below).
  always_comb begin
    wr_any = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    case (state)
      IDLE: if (load_en && in_range(load_addr)) begin
        wr_any = 1'b1;
        wr_idx = load_addr;
        wr_val = load_data;
      end
      S1: begin wr_any = 1'b1; wr_idx = ri; wr_val = op1; end
      S2: begin wr_any = 1'b1; wr_idx = rj; wr_val = op2; end
      S3: begin wr_any = 1'b1; wr_idx = ri; wr_val = op2; end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  assign accept  = cmd_valid && (state == IDLE);
  assign cmd_bad = !in_range(cmd_i) || !in_range(cmd_j);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid) begin
        // Rejected and i==j commands both finish immediately with no write.
        if (cmd_bad || cmd_i == cmd_j) state_nx = FIN;
        else                           state_nx = S1;
      end
      S1:      state_nx = S2;
      S2:      state_nx = S3;
      S3:      state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ri        <= '0;
      rj        <= '0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      load_err  <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      if (accept) begin
        ri <= cmd_i;
        rj <= cmd_j;
      end
      done      <= (state_nx == FIN);
      cmd_err   <= accept && cmd_bad;
      load_err  <= load_en && (state != IDLE);
      busy      <= (state_nx == S1) || (state_nx == S2) || (state_nx == S3);
      cmd_ready <= (state_nx == IDLE);
    end
  end

endmodule
